// File: rtl/coherence_pkg.sv
// coherence_pkg: shared bus-operation, MSI line-state and agent-state encodings.
package coherence_pkg;
  typedef enum logic [1:0] {BUS_RD = 2'b00, BUS_UPGR = 2'b01, BUS_RDX = 2'b10, BUS_NON = 2'b11} bus_op_t;
  typedef enum logic [1:0] {MSI_I = 2'b00, MSI_S = 2'b01, MSI_M = 2'b10} msi_state_t;
  typedef enum logic [1:0] {IDLE, REQ, RESP} agent_state_t;
endpackage

// File: rtl/snoop_responder.sv
// snoop_responder: combinational hit/data/flush answer to peer snoops plus registered line-update pulses.
module snoop_responder
  import coherence_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  snoop_operation_in,
  input  logic [31:0] snoop_address_in,
  input  logic [1:0]  snoop_line_state,
  input  logic [31:0] snoop_line_data,
  output logic [31:0] bus_data_out,
  output logic        cache_hit_out,
  output logic        flush_out,
  output logic        snoop_inval,
  output logic        snoop_downgrade,
  output logic [31:0] snoop_upd_addr
);
  logic holds, supply, kill, demote;
  assign holds = snoop_line_state == MSI_S || snoop_line_state == MSI_M;
  assign supply = holds && (snoop_operation_in == BUS_RD || snoop_operation_in == BUS_RDX);
  assign cache_hit_out = supply;
  assign bus_data_out = supply ? snoop_line_data : '0;
  assign flush_out = supply && snoop_line_state == MSI_M;
  assign kill = (holds && snoop_operation_in == BUS_RDX) ||
                (snoop_operation_in == BUS_UPGR && snoop_line_state == MSI_S);
  assign demote = snoop_operation_in == BUS_RD && snoop_line_state == MSI_M;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      snoop_inval <= 1'b0;
      snoop_downgrade <= 1'b0;
      snoop_upd_addr <= '0;
    end else begin
      snoop_inval <= kill;
      snoop_downgrade <= demote;
      if (kill || demote) snoop_upd_addr <= snoop_address_in;
    end
endmodule

// File: rtl/cache_bus_agent.sv
// cache_bus_agent: per-core initiator FSM turning cache misses/upgrades into arbitrated bus
// transactions, with a snoop responder for the peer core.
module cache_bus_agent
  import coherence_pkg::*;
#(
  parameter int WAIT_CNT_W = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  cpu_req_valid,
  input  logic [1:0]            cpu_req_op,
  input  logic [31:0]           cpu_req_addr,
  output logic                  cpu_req_ready,
  output logic                  cpu_resp_valid,
  output logic [31:0]           cpu_resp_data,
  output logic                  cpu_resp_shared,
  output logic                  req_core,
  input  logic                  grant_core,
  output logic [1:0]            bus_operation_out,
  output logic [31:0]           bus_address_out,
  input  logic [31:0]           bus_data_in,
  input  logic                  cache_hit_in,
  input  logic [1:0]            snoop_operation_in,
  input  logic [31:0]           snoop_address_in,
  output logic [31:0]           snoop_lookup_addr,
  input  logic [1:0]            snoop_line_state,
  input  logic [31:0]           snoop_line_data,
  output logic [31:0]           bus_data_out,
  output logic                  cache_hit_out,
  output logic                  flush_out,
  output logic                  snoop_inval,
  output logic                  snoop_downgrade,
  output logic [31:0]           snoop_upd_addr,
  output logic [WAIT_CNT_W-1:0] bus_wait_cycles
);
  agent_state_t state;
  logic promote, upgr;
  assign cpu_req_ready = state == IDLE;
  assign snoop_lookup_addr = snoop_address_in;
  assign upgr = bus_operation_out == BUS_UPGR;
  // A peer invalidating our line while our upgrade waits means we no longer hold a copy.
  assign promote = upgr && snoop_address_in == bus_address_out &&
                   (snoop_operation_in == BUS_RDX || snoop_operation_in == BUS_UPGR);
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state <= IDLE;
      req_core <= 1'b0;
      bus_operation_out <= BUS_NON;
      bus_address_out <= '0;
      cpu_resp_valid <= 1'b0;
      cpu_resp_data <= '0;
      cpu_resp_shared <= 1'b0;
      bus_wait_cycles <= '0;
    end else
      case (state)
        IDLE:
          if (cpu_req_valid && cpu_req_op != BUS_NON) begin
            state <= REQ;
            req_core <= 1'b1;
            bus_operation_out <= cpu_req_op;
            bus_address_out <= cpu_req_addr;
          end
        REQ:
          if (grant_core) begin
            state <= RESP;
            req_core <= 1'b0;
            bus_operation_out <= BUS_NON;
            cpu_resp_valid <= 1'b1;
            cpu_resp_data <= (upgr || !cache_hit_in) ? '0 : bus_data_in;
            cpu_resp_shared <= !upgr && cache_hit_in;
          end else begin
            bus_wait_cycles <= &bus_wait_cycles ? bus_wait_cycles : bus_wait_cycles + 1'b1;
            if (promote) bus_operation_out <= BUS_RDX;
          end
        default: begin
          state <= IDLE;
          cpu_resp_valid <= 1'b0;
        end
      endcase
  snoop_responder u_snoop (
    .clk               (clk),
    .reset             (reset),
    .snoop_operation_in(snoop_operation_in),
    .snoop_address_in  (snoop_address_in),
    .snoop_line_state  (snoop_line_state),
    .snoop_line_data   (snoop_line_data),
    .bus_data_out      (bus_data_out),
    .cache_hit_out     (cache_hit_out),
    .flush_out         (flush_out),
    .snoop_inval       (snoop_inval),
    .snoop_downgrade   (snoop_downgrade),
    .snoop_upd_addr    (snoop_upd_addr)
  );
endmodule

// File: tb/tb_cache_bus_agent.sv
// tb_cache_bus_agent: directed plus randomized checks of the bus agent against a transaction-level model.
module tb_cache_bus_agent;
  logic        clk = 0, reset = 1;
  logic        cpu_req_valid = 0;
  logic [1:0]  cpu_req_op = 0;
  logic [31:0] cpu_req_addr = 0;
  logic        cpu_req_ready, cpu_resp_valid, cpu_resp_shared, req_core;
  logic [31:0] cpu_resp_data, bus_address_out, bus_data_out, snoop_lookup_addr, snoop_upd_addr;
  logic        grant_core = 0, cache_hit_in = 0;
  logic [1:0]  bus_operation_out;
  logic [31:0] bus_data_in = 0, snoop_address_in = 0, snoop_line_data = 0;
  logic [1:0]  snoop_operation_in = 2'b11, snoop_line_state = 0;
  logic        cache_hit_out, flush_out, snoop_inval, snoop_downgrade;
  logic [15:0] bus_wait_cycles;
  int errors = 0, checks = 0, wait_exp = 0;

  cache_bus_agent dut (
    .clk(clk), .reset(reset), .cpu_req_valid(cpu_req_valid), .cpu_req_op(cpu_req_op),
    .cpu_req_addr(cpu_req_addr), .cpu_req_ready(cpu_req_ready), .cpu_resp_valid(cpu_resp_valid),
    .cpu_resp_data(cpu_resp_data), .cpu_resp_shared(cpu_resp_shared), .req_core(req_core),
    .grant_core(grant_core), .bus_operation_out(bus_operation_out), .bus_address_out(bus_address_out),
    .bus_data_in(bus_data_in), .cache_hit_in(cache_hit_in), .snoop_operation_in(snoop_operation_in),
    .snoop_address_in(snoop_address_in), .snoop_lookup_addr(snoop_lookup_addr),
    .snoop_line_state(snoop_line_state), .snoop_line_data(snoop_line_data), .bus_data_out(bus_data_out),
    .cache_hit_out(cache_hit_out), .flush_out(flush_out), .snoop_inval(snoop_inval),
    .snoop_downgrade(snoop_downgrade), .snoop_upd_addr(snoop_upd_addr), .bus_wait_cycles(bus_wait_cycles)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One complete own transaction: expected response derived from the op/hit rules only.
  task automatic xact(input logic [1:0] op, input logic [31:0] addr, input int deny,
                      input logic hit, input logic [31:0] data);
    logic [31:0] exp_data;
    logic        exp_shared;
    exp_shared = hit && op != 2'b01;
    exp_data = exp_shared ? data : 32'h0;
    chk("ready_idle", cpu_req_ready, 1);
    cpu_req_valid = 1; cpu_req_op = op; cpu_req_addr = addr;
    tick;
    cpu_req_valid = 0;
    for (int i = 0; i < deny; i++) begin
      grant_core = 0;
      #1;
      chk("req_held", req_core, 1);
      chk("op_held", bus_operation_out, op);
      chk("addr_held", bus_address_out, addr);
      chk("no_early_resp", cpu_resp_valid, 0);
      tick;
      wait_exp = wait_exp < 65535 ? wait_exp + 1 : wait_exp;
    end
    grant_core = 1; cache_hit_in = hit; bus_data_in = data;
    #1;
    chk("req_at_grant", req_core, 1);
    tick;
    grant_core = 0; cache_hit_in = 0;
    chk("resp_valid", cpu_resp_valid, 1);
    chk("resp_data", cpu_resp_data, exp_data);
    chk("resp_shared", cpu_resp_shared, exp_shared);
    chk("req_dropped", req_core, 0);
    chk("op_non", bus_operation_out, 2'b11);
    chk("ready_busy", cpu_req_ready, 0);
    chk("wait_cnt", bus_wait_cycles, wait_exp);
    tick;
    chk("resp_pulse_end", cpu_resp_valid, 0);
  endtask

  // Snoop rules: who holds a copy supplies it, dirty copies flush, exclusive requests kill copies.
  task automatic snoop(input logic [1:0] op, input logic [1:0] st, input logic [31:0] addr, input logic [31:0] data);
    logic valid_copy, supplies, kills, demotes;
    valid_copy = st == 2'b01 || st == 2'b10;
    supplies = valid_copy && (op == 2'b00 || op == 2'b10);
    kills = (valid_copy && op == 2'b10) || (op == 2'b01 && st == 2'b01);
    demotes = op == 2'b00 && st == 2'b10;
    snoop_operation_in = op; snoop_line_state = st; snoop_address_in = addr; snoop_line_data = data;
    #1;
    chk("snp_hit", cache_hit_out, supplies);
    chk("snp_data", bus_data_out, supplies ? data : 32'h0);
    chk("snp_flush", flush_out, supplies && st == 2'b10);
    chk("snp_lookup", snoop_lookup_addr, addr);
    chk("snp_no_early_pulse", snoop_inval | snoop_downgrade, 0);
    tick;
    snoop_operation_in = 2'b11;
    chk("snp_inval", snoop_inval, kills);
    chk("snp_down", snoop_downgrade, demotes);
    if (kills || demotes) chk("snp_upd_addr", snoop_upd_addr, addr);
    tick;
    chk("snp_pulse_end", snoop_inval | snoop_downgrade, 0);
  endtask

  initial begin
    logic [1:0]  op;
    logic [31:0] a, d;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_req", req_core, 0);
    chk("rst_op", bus_operation_out, 2'b11);
    chk("rst_addr", bus_address_out, 0);
    chk("rst_resp", {cpu_resp_valid, cpu_resp_shared} , 0);
    chk("rst_resp_data", cpu_resp_data, 0);
    chk("rst_pulses", {snoop_inval, snoop_downgrade}, 0);
    chk("rst_upd_addr", snoop_upd_addr, 0);
    chk("rst_wait", bus_wait_cycles, 0);
    reset = 0;
    tick;
    xact(2'b00, 32'h100, 0, 1, 32'hDEADBEEF);
    xact(2'b10, 32'h200, 3, 0, 32'h0);
    snoop(2'b00, 2'b10, 32'h300, 32'h12345678);
    snoop(2'b10, 2'b01, 32'h340, 32'hCAFEF00D);
    for (int n = 0; n < 10; n++) begin
      op = 2'($urandom_range(0, 3));
      a = $urandom; d = $urandom;
      if (op == 2'b11) begin
        cpu_req_valid = 1; cpu_req_op = op; cpu_req_addr = a;
        tick;
        cpu_req_valid = 0;
        chk("illegal_ignored", req_core, 0);
        chk("illegal_ready", cpu_req_ready, 1);
      end else xact(op, a, $urandom_range(0, 3), 1'($urandom), d);
    end
    for (int n = 0; n < 20; n++) snoop(2'($urandom_range(0, 3)), 2'($urandom_range(0, 2)), $urandom, $urandom);
    // Upgrade pending: unrelated snoops leave it alone, a matching BusRdX promotes it.
    d = $urandom;
    cpu_req_valid = 1; cpu_req_op = 2'b01; cpu_req_addr = 32'h400;
    tick;
    cpu_req_valid = 0;
    snoop_operation_in = 2'b00; snoop_line_state = 2'b10; snoop_address_in = 32'h400; snoop_line_data = d;
    #1;
    chk("concurrent_hit", cache_hit_out, 1);
    chk("concurrent_data", bus_data_out, d);
    tick;
    wait_exp++;
    snoop_operation_in = 2'b10; snoop_line_state = 2'b00; snoop_address_in = 32'h404;
    #1;
    chk("no_promote_rd", bus_operation_out, 2'b01);
    tick;
    wait_exp++;
    snoop_address_in = 32'h400;
    #1;
    chk("no_promote_other_addr", bus_operation_out, 2'b01);
    tick;
    wait_exp++;
    snoop_operation_in = 2'b11;
    chk("promoted", bus_operation_out, 2'b10);
    chk("promoted_req", req_core, 1);
    grant_core = 1; cache_hit_in = 1; bus_data_in = d;
    tick;
    grant_core = 0; cache_hit_in = 0;
    chk("promoted_resp", cpu_resp_valid, 1);
    chk("promoted_data", cpu_resp_data, d);
    chk("promoted_wait", bus_wait_cycles, wait_exp);
    tick;
    cpu_req_valid = 1; cpu_req_op = 2'b00; cpu_req_addr = $urandom;
    tick;
    cpu_req_valid = 0;
    chk("pre_rst_req", req_core, 1);
    reset = 1;
    #1;
    chk("async_rst_req", req_core, 0);
    chk("async_rst_op", bus_operation_out, 2'b11);
    chk("async_rst_wait", bus_wait_cycles, 0);
    grant_core = 1;
    tick;
    reset = 0;
    wait_exp = 0;
    for (int i = 0; i < 3; i++) begin
      tick;
      chk("no_resp_after_rst", cpu_resp_valid, 0);
      chk("idle_after_rst", req_core, 0);
    end
    grant_core = 0;
    xact(2'b00, 32'h500, 1, 1, 32'h55AA55AA);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
